iru_tx_ctrl: RTL

//  Transmit side of the IRU->BCAU image interface. Collects one image from the upstream rotation

---
 rtl/iru_bcau_pkg.sv | 14 +
 rtl/iru_tx_ctrl_if.sv | 24 ++
 rtl/iru_tx_bank.sv | 28 ++
 rtl/iru_tx_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/iru_bcau_pkg.sv
// Shared geometry defaults and FSM state type for the IRU -> BCAU image transmit path.
package iru_bcau_pkg;

   localparam int DEFAULT_WORD_W    = 40;
   localparam int DEFAULT_NUM_WORDS = 80;

   typedef enum logic [1:0] {FILL, WAIT, SEND} iru_tx_state;

   // Index width that stays legal for a one-word image.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/iru_tx_ctrl_if.sv
// Word-stream input and parallel image output of iru_tx_ctrl, grouped as one bus.
// master: the transmit controller itself; slave: upstream core plus BCAU.
interface iru_tx_ctrl_if #(
   parameter int WORD_W    = iru_bcau_pkg::DEFAULT_WORD_W,
   parameter int NUM_WORDS = iru_bcau_pkg::DEFAULT_NUM_WORDS
);
   logic                        in_valid;
   logic                        in_sof;
   logic [WORD_W-1:0]           in_data;
   logic                        in_ready;
   logic                        bcau_ready;
   logic                        iru_valid;
   logic [NUM_WORDS*WORD_W-1:0] iru_img;

   modport master (
      input  in_valid, in_sof, in_data, bcau_ready,
      output in_ready, iru_valid, iru_img
   );

   modport slave (
      output in_valid, in_sof, in_data, bcau_ready,
      input  in_ready, iru_valid, iru_img
   );
endinterface

// File: rtl/iru_tx_bank.sv
// One image buffer: indexed single-word write, whole image readable in parallel.
module iru_tx_bank #(
   parameter int WORD_W    = 40,
   parameter int NUM_WORDS = 80,
   parameter int IDX_W     = 7
) (
   input  logic                        clk,
   input  logic                        we,
   input  logic [IDX_W-1:0]            wr_idx,
   input  logic [WORD_W-1:0]           wr_data,
   output logic [NUM_WORDS*WORD_W-1:0] rd_all
);
   // Contents are never reset; the image bus is only meaningful during a send.
   logic [WORD_W-1:0] mem_reg [NUM_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_reg[wr_idx] <= wr_data;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_WORDS; gi++) begin : g_rd
         assign rd_all[gi*WORD_W +: WORD_W] = mem_reg[gi];
      end
   endgenerate
endmodule

// File: rtl/iru_tx_ctrl.sv
// IRU -> BCAU transmit controller: buffers one serial image, then issues a one-cycle load pulse.
// Define IRU_TX_PINGPONG_EN to double-buffer so the next image can fill while one waits to send.
module iru_tx_ctrl
   import iru_bcau_pkg::*;
#(
   parameter int WORD_W    = DEFAULT_WORD_W,
   parameter int NUM_WORDS = DEFAULT_NUM_WORDS
) (
   input logic           clk,
   input logic           rst,
   iru_tx_ctrl_if.master bus
);
   localparam int               CNT_W    = cnt_width(NUM_WORDS);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);
`ifdef IRU_TX_PINGPONG_EN
   localparam int NUM_BANKS = 2;
`else
   localparam int NUM_BANKS = 1;
`endif

   iru_tx_state                 state_reg;
   logic [CNT_W-1:0]            wr_cnt_reg;
   logic [CNT_W-1:0]            wr_cnt_next;
   logic [CNT_W-1:0]            wr_idx;
   logic                        bcau_ready_q;
   logic                        accept;
   logic                        wrap;
   logic                        send_done;
   logic                        fill_full;
   logic                        tx_full_next;
   logic [NUM_BANKS-1:0]        bank_we;
   logic [NUM_WORDS*WORD_W-1:0] bank_rd [NUM_BANKS];

   // Both outputs are forced low during reset so an in-flight image is dropped silently.
   assign bus.in_ready  = !rst && !fill_full;
   assign bus.iru_valid = !rst && (state_reg == SEND);

   assign accept    = bus.in_valid && bus.in_ready;
   assign wrap      = accept && !bus.in_sof && (wr_cnt_reg == LAST_IDX);
   assign send_done = (state_reg == SEND);
   assign wr_idx    = bus.in_sof ? '0 : wr_cnt_reg;

   always_comb begin
      wr_cnt_next = wr_cnt_reg;
      if (accept) begin
         if (bus.in_sof) begin
            wr_cnt_next = CNT_W'(1);
         end else if (wrap) begin
            wr_cnt_next = '0;
         end else begin
            wr_cnt_next = wr_cnt_reg + CNT_W'(1);
         end
      end
   end

   // bcau_ready is only consumed through bcau_ready_q: BCAU drops it combinationally during
   // iru_valid, so the registered copy blocks a second pulse right after a send.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= FILL;
         wr_cnt_reg   <= '0;
         bcau_ready_q <= 1'b0;
      end else begin
         bcau_ready_q <= bus.bcau_ready;
         wr_cnt_reg   <= wr_cnt_next;
         case (state_reg)
            FILL:    if (tx_full_next) state_reg <= WAIT;
            WAIT:    if (bcau_ready_q) state_reg <= SEND;
            SEND:    state_reg <= tx_full_next ? WAIT : FILL;
            default: state_reg <= FILL;
         endcase
      end
   end

`ifdef IRU_TX_PINGPONG_EN
   logic [1:0] full_reg;
   logic [1:0] full_next;
   logic       fill_sel_reg;
   logic       fill_sel_next;
   logic       tx_sel_reg;
   logic       tx_sel_next;

   // Banks fill strictly alternately, so the send pointer simply alternates after each send.
   always_comb begin
      full_next = full_reg;
      if (wrap) full_next[fill_sel_reg] = 1'b1;
      if (send_done) full_next[tx_sel_reg] = 1'b0;
      tx_sel_next   = send_done ? ~tx_sel_reg : tx_sel_reg;
      fill_sel_next = fill_sel_reg;
      if (full_next[fill_sel_reg] && !full_next[~fill_sel_reg]) begin
         fill_sel_next = ~fill_sel_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_reg     <= '0;
         fill_sel_reg <= 1'b0;
         tx_sel_reg   <= 1'b0;
      end else begin
         full_reg     <= full_next;
         fill_sel_reg <= fill_sel_next;
         tx_sel_reg   <= tx_sel_next;
      end
   end

   assign fill_full    = full_reg[fill_sel_reg];
   assign tx_full_next = full_next[tx_sel_next];
   assign bank_we      = {accept && fill_sel_reg, accept && !fill_sel_reg};
   assign bus.iru_img  = bank_rd[tx_sel_reg];
`else
   logic full_reg;
   logic full_next;

   assign full_next = wrap ? 1'b1 : (send_done ? 1'b0 : full_reg);

   always_ff @(posedge clk) begin
      if (rst) begin
         full_reg <= 1'b0;
      end else begin
         full_reg <= full_next;
      end
   end

   assign fill_full    = full_reg;
   assign tx_full_next = full_next;
   assign bank_we      = accept;
   assign bus.iru_img  = bank_rd[0];
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
         iru_tx_bank #(
            .WORD_W   (WORD_W),
            .NUM_WORDS(NUM_WORDS),
            .IDX_W    (CNT_W)
         ) u_bank (
            .clk    (clk),
            .we     (bank_we[gi]),
            .wr_idx (wr_idx),
            .wr_data(bus.in_data),
            .rd_all (bank_rd[gi])
         );
      end
   endgenerate
endmodule
